// File: rtl/gold_seq_pkg.sv
// Shared constants and FSM encoding for the parallel Gold sequence generator.
package gold_seq_pkg;

  localparam int unsigned LFSR_W     = 31;
  localparam logic [30:0] X1_TAPS    = 31'h0000_0009;
  localparam logic [30:0] X2_TAPS    = 31'h0000_000F;
  localparam logic [30:0] X1_INIT    = 31'd1;
  localparam int unsigned NC_DEFAULT = 1600;

  typedef enum logic [1:0] {
    IDLE,
    WARM,
    RUN
  } gold_state_e;

endpackage

// File: rtl/lfsr31_par.sv
// 31-bit Fibonacci LFSR advancing STEP positions per enabled cycle.
// Bit j of the register holds x(m+j); the lowest OBS_W bits are exposed.
module lfsr31_par
  import gold_seq_pkg::*;
#(
  parameter logic [LFSR_W-1:0] TAPS  = X1_TAPS,
  parameter int unsigned       STEP  = 1,
  parameter int unsigned       OBS_W = LFSR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              adv,
  output logic [OBS_W-1:0]  state
);

  logic [LFSR_W-1:0] state_q, state_d, step_c;

  // Unrolled STEP-step update; each new bit only depends on the current window.
  always_comb begin
    step_c = state_q;
    for (int unsigned s = 0; s < STEP; s++) begin
      step_c = {^(step_c & TAPS), step_c[LFSR_W-1:1]};
    end
    state_d = state_q;
    if (load) begin
      state_d = seed;
    end else if (adv) begin
      state_d = step_c;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q[OBS_W-1:0];

endmodule

// File: rtl/gold_seq_gen_par.sv
// Gold sequence generator: skips NC chips after seeding, then streams OUT_W
// chips per word over a valid/ready interface with last/done/abort.
module gold_seq_gen_par
  import gold_seq_pkg::*;
#(
  parameter int unsigned OUT_W = 2,
  parameter int unsigned NC    = NC_DEFAULT,
  parameter int unsigned LEN_W = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [30:0]      c_init,
  input  logic [LEN_W-1:0] seq_len,
  input  logic             abort,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] c_out,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  localparam int unsigned WARM_CYC = NC / OUT_W;
  localparam int unsigned WARM_W   = (WARM_CYC > 1) ? $clog2(WARM_CYC) : 1;
  localparam int unsigned SUM_W    = LEN_W + 1;

  if (OUT_W < 1 || OUT_W > 16 || (NC % OUT_W) != 0) begin : g_param_check
    $error("gold_seq_gen_par: OUT_W must be in 1..16 and divide NC");
  end

  gold_state_e       state_q, state_d;
  logic [LEN_W-1:0]  words_q, words_d;
  logic [WARM_W-1:0] warm_q, warm_d;
  logic [OUT_W-1:0]  mask_q, mask_d;
  logic              valid_q, last_q, busy_q, done_q, done_d;
  logic              load_c, adv_c;
  logic [OUT_W-1:0]  x1_win, x2_win;
  logic [SUM_W-1:0]  len_sum_c;
  logic [LEN_W-1:0]  words_init_c, len_rem_c;
  logic [OUT_W-1:0]  mask_init_c;

  lfsr31_par #(.TAPS(X1_TAPS), .STEP(OUT_W), .OBS_W(OUT_W)) u_x1 (
    .clk  (clk),
    .rst  (rst),
    .load (load_c),
    .seed (X1_INIT),
    .adv  (adv_c),
    .state(x1_win)
  );

  lfsr31_par #(.TAPS(X2_TAPS), .STEP(OUT_W), .OBS_W(OUT_W)) u_x2 (
    .clk  (clk),
    .rst  (rst),
    .load (load_c),
    .seed (c_init),
    .adv  (adv_c),
    .state(x2_win)
  );

  // Word count and valid-bit mask for the final (possibly partial) word.
  always_comb begin
    len_sum_c    = SUM_W'(seq_len) + SUM_W'(OUT_W - 1);
    words_init_c = LEN_W'(len_sum_c / SUM_W'(OUT_W));
    len_rem_c    = seq_len % LEN_W'(OUT_W);
    for (int unsigned i = 0; i < OUT_W; i++) begin
      mask_init_c[i] = (len_rem_c == '0) || (LEN_W'(i) < len_rem_c);
    end
  end

  always_comb begin
    state_d = state_q;
    words_d = words_q;
    warm_d  = warm_q;
    mask_d  = mask_q;
    done_d  = 1'b0;
    load_c  = 1'b0;
    adv_c   = 1'b0;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (seq_len == '0) begin
              done_d = 1'b1;
            end else begin
              load_c  = 1'b1;
              words_d = words_init_c;
              warm_d  = '0;
              mask_d  = mask_init_c;
              state_d = (WARM_CYC > 0) ? WARM : RUN;
            end
          end
        end
        WARM: begin
          adv_c  = 1'b1;
          warm_d = warm_q + WARM_W'(1);
          if (warm_q == WARM_W'(WARM_CYC - 1)) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (out_ready) begin
            adv_c   = 1'b1;
            words_d = words_q - LEN_W'(1);
            if (words_q == LEN_W'(1)) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      words_q <= '0;
      warm_q  <= '0;
      mask_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      words_q <= words_d;
      warm_q  <= warm_d;
      mask_q  <= mask_d;
      valid_q <= (state_d == RUN);
      last_q  <= (state_d == RUN) && (words_d == LEN_W'(1));
      busy_q  <= (state_d != IDLE);
      done_q  <= done_d;
    end
  end

  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign c_out     = valid_q ? ((x1_win ^ x2_win) & (last_q ? mask_q : '1)) : '0;

endmodule

// File: tb/tb_gold_seq_gen_par.sv
// Bench for gold_seq_gen_par: array-based Gold reference, per-cycle compare,
// directed NC=0 instance and randomized NC=1600 traffic.
`timescale 1ns/1ps
module tb_gold_seq_gen_par;

  localparam int unsigned OUT_W = 2;
  localparam int unsigned NC    = 1600;
  localparam int unsigned LEN_W = 13;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [30:0]      c_init = '0;
  logic [LEN_W-1:0] seq_len = '0;
  logic             abort = 1'b0;
  logic             out_ready = 1'b1;
  logic             out_valid;
  logic [OUT_W-1:0] c_out;
  logic             out_last, busy, done;

  logic             b_start = 1'b0;
  logic [LEN_W-1:0] b_len = '0;
  logic             b_valid, b_last, b_busy, b_done;
  logic [1:0]       b_c;

  int checks = 0;
  int failures = 0;
  int rdy_mode = 0;
  int rdy_cnt = 0;
  bit en_cmp = 1'b0;

  always #5 clk = ~clk;

  gold_seq_gen_par #(.OUT_W(OUT_W), .NC(NC), .LEN_W(LEN_W)) u_dut (
    .clk(clk), .rst(rst), .start(start), .c_init(c_init), .seq_len(seq_len),
    .abort(abort), .out_ready(out_ready), .out_valid(out_valid), .c_out(c_out),
    .out_last(out_last), .busy(busy), .done(done)
  );

  gold_seq_gen_par #(.OUT_W(2), .NC(0), .LEN_W(LEN_W)) u_nc0 (
    .clk(clk), .rst(rst), .start(b_start), .c_init(31'd0), .seq_len(b_len),
    .abort(1'b0), .out_ready(1'b1), .out_valid(b_valid), .c_out(b_c),
    .out_last(b_last), .busy(b_busy), .done(b_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: build x1/x2 directly from their recurrences, c(n) = x1(n+nc)^x2(n+nc).
  bit gen_q[$];
  task automatic gen_bits(input logic [30:0] ci, input int nc, input int len);
    bit x1[];
    bit x2[];
    x1 = new[nc + len + 31];
    x2 = new[nc + len + 31];
    for (int n = 0; n < 31; n++) begin
      x1[n] = (n == 0);
      x2[n] = ci[n];
    end
    for (int n = 0; n < nc + len; n++) begin
      x1[n+31] = x1[n+3] ^ x1[n];
      x2[n+31] = x2[n+3] ^ x2[n+2] ^ x2[n+1] ^ x2[n];
    end
    gen_q.delete();
    for (int n = 0; n < len; n++) gen_q.push_back(x1[n+nc] ^ x2[n+nc]);
  endtask

  // Transaction-level model of the expected output stream.
  bit exp_bits[$];
  bit m_busy = 1'b0;
  bit m_done = 1'b0;
  int m_warm = 0, m_word = 0, m_words = 0, m_len = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_warm = 0; m_word = 0; m_words = 0;
    end else begin
      m_done = 1'b0;
      if (abort) begin
        m_busy = 1'b0;
      end else if (!m_busy) begin
        if (start) begin
          if (seq_len == '0) begin
            m_done = 1'b1;
          end else begin
            m_len = int'(seq_len);
            gen_bits(c_init, NC, m_len);
            exp_bits = gen_q;
            m_words = (m_len + OUT_W - 1) / OUT_W;
            m_word = 0;
            m_warm = NC / OUT_W;
            m_busy = 1'b1;
          end
        end
      end else if (m_warm > 0) begin
        m_warm--;
      end else if (out_ready) begin
        m_word++;
        if (m_word == m_words) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end
    end
  end

  function automatic logic [OUT_W-1:0] exp_word(input int k);
    logic [OUT_W-1:0] w;
    w = '0;
    for (int i = 0; i < OUT_W; i++) if (k * OUT_W + i < m_len) w[i] = exp_bits[k*OUT_W+i];
    return w;
  endfunction

  bit cmp_v;
  always @(negedge clk) begin
    if (rst && en_cmp) begin
      cmp_v = m_busy && (m_warm == 0);
      chk("busy", 32'(busy), 32'(m_busy));
      chk("out_valid", 32'(out_valid), 32'(cmp_v));
      chk("done", 32'(done), 32'(m_done));
      if (cmp_v) begin
        chk("c_out", 32'(c_out), 32'(exp_word(m_word)));
        chk("out_last", 32'(out_last), 32'(m_word == m_words - 1));
      end else begin
        chk("out_last_idle", 32'(out_last), 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    rdy_cnt++;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = ((rdy_cnt % 3) == 0);
    endcase
  end

  task automatic wait_idle(input int limit);
    int n = 0;
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("sequence_finished", 32'(busy), 32'd0);
  endtask

  task automatic run_seq(input logic [30:0] ci, input int len, input bit measure, input bit b2b);
    int n;
    if (!b2b) @(negedge clk);
    c_init = ci;
    seq_len = LEN_W'(len);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c_init = 31'($urandom);
    seq_len = LEN_W'($urandom);
    n = 1;
    if (measure) begin
      while (!out_valid && n < 2000) begin
        @(negedge clk);
        n++;
      end
      chk("first_valid_latency", 32'(n), 32'd801);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(4000);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    gen_bits(31'd0, 0, 33);
    n = 0;
    for (int i = 1; i < 31; i++) n += int'(gen_q[i]);
    chk("pin_c0", 32'(gen_q[0]), 32'd1);
    chk("pin_c1_30_ones", 32'(n), 32'd0);
    chk("pin_c31", 32'(gen_q[31]), 32'd1);
    chk("pin_c32", 32'(gen_q[32]), 32'd0);
    gen_bits(31'd1, 0, 32);
    chk("pin_seed1_c0", 32'(gen_q[0]), 32'd0);
    chk("pin_seed1_c31", 32'(gen_q[31]), 32'd0);

    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_c_out", 32'(c_out), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    en_cmp = 1'b1;

    b_len = LEN_W'(4);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    chk("nc0_first_valid", 32'(b_valid), 32'd1);
    chk("nc0_word0", 32'(b_c), 32'h1);
    chk("nc0_last0", 32'(b_last), 32'd0);
    @(negedge clk);
    chk("nc0_word1", 32'(b_c), 32'h0);
    chk("nc0_last1", 32'(b_last), 32'd1);
    @(negedge clk);
    chk("nc0_valid_end", 32'(b_valid), 32'd0);
    chk("nc0_done", 32'(b_done), 32'd1);
    @(negedge clk);
    chk("nc0_done_pulse", 32'(b_done), 32'd0);

    rdy_mode = 0;
    run_seq(31'($urandom), 288, 1'b1, 1'b0);
    rdy_mode = 2;
    run_seq(31'($urandom), 5, 1'b0, 1'b0);
    rdy_mode = 1;
    run_seq(31'($urandom), 17, 1'b0, 1'b1);

    rdy_mode = 0;
    @(negedge clk);
    c_init = 31'($urandom); seq_len = LEN_W'(20); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_warm_busy", 32'(busy), 32'd0);
    chk("abort_warm_done", 32'(done), 32'd0);

    c_init = 31'($urandom); seq_len = LEN_W'(6); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!out_last && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("abort_run_reached_last", 32'(out_last), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_run_valid", 32'(out_valid), 32'd0);
    chk("abort_run_done", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    run_seq(31'($urandom), 9, 1'b0, 1'b0);

    @(negedge clk);
    seq_len = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("zero_len_done", 32'(done), 32'd1);
    chk("zero_len_valid", 32'(out_valid), 32'd0);
    seq_len = LEN_W'(10); start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort_beats_start", 32'(busy), 32'd0);

    c_init = 31'($urandom); seq_len = LEN_W'(40); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (805) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_c_out", 32'(c_out), 32'd0);
    chk("async_rst_last", 32'(out_last), 32'd0);
    chk("async_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    rdy_mode = 1;
    for (int r = 0; r < 4; r++) begin
      run_seq(31'($urandom), $urandom_range(1, 40), 1'b0, r[0]);
    end
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
